// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 16-bit words over a req/ack
// handshake and holds each one in the IR until decode accepts it.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        ir_valid,
    output logic [15:0] ir,
    output logic [15:0] ir_pc,
    output logic [3:0]  opcode,
    output logic [7:0]  imm8
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_mem_req;
    logic [15:0] r_mem_addr;
    logic        r_ir_valid;
    logic [15:0] r_ir;
    logic [15:0] r_ir_pc;

    logic [15:0] w_redirect_pc;
    logic [15:0] w_pc_next;

    // Instructions are halfword aligned, so a redirect target is forced even.
    assign w_redirect_pc = {redirect_pc[15:1], 1'b0};
    assign w_pc_next     = r_pc + PC_STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
            r_ir_valid <= 1'b0;
            r_ir       <= 16'h0000;
            r_ir_pc    <= 16'h0000;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_mem_req) begin
                        // Only reachable straight out of reset: start the first request.
                        r_mem_req <= 1'b1;
                        if (redirect) begin
                            r_pc       <= w_redirect_pc;
                            r_mem_addr <= w_redirect_pc;
                        end else begin
                            r_mem_addr <= r_pc;
                        end
                    end else if (redirect) begin
                        r_pc <= w_redirect_pc;
                        if (mem_ack) begin
                            r_mem_addr <= w_redirect_pc;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (mem_ack) begin
                        r_ir       <= mem_rdata;
                        r_ir_pc    <= r_pc;
                        r_pc       <= w_pc_next;
                        r_ir_valid <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_state    <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        r_pc       <= w_redirect_pc;
                        r_ir_valid <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= w_redirect_pc;
                        r_state    <= S_FETCH;
                    end else if (dec_ready) begin
                        r_ir_valid <= 1'b0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_pc;
                        r_state    <= S_FETCH;
                    end
                end

                S_DRAIN: begin
                    // The stale request must complete before the bus can move on.
                    if (redirect) begin
                        r_pc <= w_redirect_pc;
                        if (mem_ack) begin
                            r_mem_addr <= w_redirect_pc;
                            r_state    <= S_FETCH;
                        end
                    end else if (mem_ack) begin
                        r_mem_addr <= r_pc;
                        r_state    <= S_FETCH;
                    end
                end

                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign ir_valid = r_ir_valid;
    assign ir       = r_ir;
    assign ir_pc    = r_ir_pc;
    assign opcode   = r_ir[15:12];
    assign imm8     = r_ir[7:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic checked
// against an instruction-stream reference model and the bus handshake rules.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        dec_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ir_valid;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic [3:0]  opcode;
    logic [7:0]  imm8;

    instr_fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .opcode     (opcode),
        .imm8       (imm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_del       = 0;

    // Sampled DUT outputs for the current cycle.
    logic        ob_req, ob_valid;
    logic [15:0] ob_addr, ob_ir, ob_irpc;
    logic [3:0]  ob_op;
    logic [7:0]  ob_imm;

    // Reference model: next instruction address owed to decode, plus the
    // consequences expected at the next sample.
    logic [15:0] exp_pc;
    logic        stale;
    logic        e_stable, e_drop, e_deliver, e_hold, e_issue;
    logic [15:0] sv_addr, sv_ir, sv_irpc;
    logic        prev_req;

    // Memory responder controls.
    int          wait_cnt, lat_tgt, fixed_lat;
    int          ack_mode;      // 0 latency based, 1 withhold, 2 ack now
    logic        rand_lat, rand_mode, ovr_en;
    logic [15:0] ovr_data;
    logic        xf;
    logic [15:0] xf_addr;

    logic [15:0] seq_q[$];

    function automatic logic [15:0] word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'hA3F0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_pc    = 16'h0000;
        stale     = 1'b0;
        e_stable  = 1'b0;
        e_drop    = 1'b0;
        e_deliver = 1'b0;
        e_hold    = 1'b0;
        e_issue   = 1'b0;
        prev_req  = 1'b0;
        wait_cnt  = 0;
        lat_tgt   = fixed_lat;
    endtask

    task automatic step(input logic rdy, input logic redir, input logic [15:0] rpc);
        logic        ack;
        logic [15:0] rdata;
        logic        r_rdy, r_redir;
        logic [15:0] r_rpc;
        logic [15:0] w;
        @(negedge clk);
        ob_req   = mem_req;
        ob_addr  = mem_addr;
        ob_valid = ir_valid;
        ob_ir    = ir;
        ob_irpc  = ir_pc;
        ob_op    = opcode;
        ob_imm   = imm8;

        if (e_stable) begin
            chk1("req_held", ob_req, 1'b1);
            chk("addr_held", ob_addr, sv_addr);
        end
        if (e_drop) chk1("valid_drop", ob_valid, 1'b0);
        if (e_deliver) begin
            chk1("dlv_valid", ob_valid, 1'b1);
            chk("dlv_ir", ob_ir, word(sv_addr));
            chk("dlv_irpc", ob_irpc, sv_addr);
            chk1("dlv_req_low", ob_req, 1'b0);
        end
        if (e_hold) begin
            chk1("hold_valid", ob_valid, 1'b1);
            chk("hold_ir", ob_ir, sv_ir);
            chk("hold_irpc", ob_irpc, sv_irpc);
        end
        if (e_issue) begin
            chk1("issue_req", ob_req, 1'b1);
            chk("issue_addr", ob_addr, exp_pc);
        end
        if (!prev_req && ob_req) chk("rise_addr", ob_addr, exp_pc);
        if (ob_valid) begin
            w = word(exp_pc);
            chk("v_irpc", ob_irpc, exp_pc);
            chk("v_ir", ob_ir, w);
            chk("v_opcode", {12'h000, ob_op}, {12'h000, w[15:12]});
            chk("v_imm8", {8'h00, ob_imm}, {8'h00, w[7:0]});
            chk1("v_no_req", ob_req, 1'b0);
        end

        if (rand_mode) begin
            r_rdy   = ($urandom_range(9) < 7);
            r_redir = (ob_req || ob_valid) && ($urandom_range(14) == 0);
            r_rpc   = 16'($urandom);
        end else begin
            r_rdy   = rdy;
            r_redir = redir;
            r_rpc   = rpc;
        end

        ack   = 1'b0;
        rdata = 16'($urandom);
        if (ob_req) begin
            case (ack_mode)
                0:       ack = (wait_cnt >= lat_tgt);
                2:       ack = 1'b1;
                default: ack = 1'b0;
            endcase
            if (ack) begin
                rdata    = ovr_en ? ovr_data : word(ob_addr);
                wait_cnt = 0;
                lat_tgt  = rand_lat ? int'($urandom_range(3)) : fixed_lat;
            end else begin
                wait_cnt++;
            end
        end else begin
            ack      = rand_mode && ($urandom_range(3) == 0);
            wait_cnt = 0;
        end

        dec_ready   = r_rdy;
        redirect    = r_redir;
        redirect_pc = r_rpc;
        mem_ack     = ack;
        mem_rdata   = rdata;

        xf        = ob_req && ack;
        xf_addr   = ob_addr;
        e_stable  = 1'b0;
        e_drop    = 1'b0;
        e_deliver = 1'b0;
        e_hold    = 1'b0;
        e_issue   = 1'b0;
        if (ob_req && !ack) begin
            e_stable = 1'b1;
            sv_addr  = ob_addr;
        end
        if (r_redir) begin
            exp_pc = r_rpc & 16'hFFFE;
            e_drop = 1'b1;
            if (ob_req && !ack) stale = 1'b1;
            if (xf) begin
                stale   = 1'b0;
                e_issue = 1'b1;
            end
        end else begin
            if (xf) begin
                if (stale) begin
                    stale   = 1'b0;
                    e_issue = 1'b1;
                end else begin
                    e_deliver = 1'b1;
                    sv_addr   = ob_addr;
                end
            end
            if (ob_valid && r_rdy) begin
                exp_pc  = exp_pc + 16'd2;
                e_issue = 1'b1;
                e_drop  = 1'b1;
                n_del++;
            end else if (ob_valid) begin
                e_hold  = 1'b1;
                sv_ir   = ob_ir;
                sv_irpc = ob_irpc;
            end
        end
        prev_req = ob_req;
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        dec_ready   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ack_mode    = 0;
        rand_lat    = 1'b0;
        rand_mode   = 1'b0;
        ovr_en      = 1'b0;
        ovr_data    = 16'h0000;
        fixed_lat   = 3;
        model_reset();

        // Reset values
        @(posedge clk);
        #2;
        chk1("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 16'h0000);
        chk1("rst_valid", ir_valid, 1'b0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_irpc", ir_pc, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Ack 3 cycles after each request, decode always ready
        step(1'b1, 1'b0, 16'h0000);
        chk1("first_req", ob_req, 1'b1);
        if (xf) seq_q.push_back(xf_addr);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, 16'h0000);
            if (xf) seq_q.push_back(xf_addr);
        end
        chk1("seq_count", seq_q.size() >= 3, 1'b1);
        if (seq_q.size() >= 3) begin
            chk("seq_addr0", seq_q[0], 16'h0000);
            chk("seq_addr1", seq_q[1], 16'h0002);
            chk("seq_addr2", seq_q[2], 16'h0004);
        end

        // Fetch A3F0 at 0000 and stall decode for 5 cycles
        step(1'b1, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !ob_valid; i++) step(1'b0, 1'b0, 16'h0000);
        chk1("b_valid_seen", ob_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 16'h0000);
            chk("b_ir", ob_ir, 16'hA3F0);
            chk("b_opcode", {12'h000, ob_op}, 16'h000A);
            chk("b_imm8", {8'h00, ob_imm}, 16'h00F0);
            chk1("b_valid", ob_valid, 1'b1);
            chk1("b_no_req", ob_req, 1'b0);
        end
        step(1'b1, 1'b0, 16'h0000);

        // Redirect to 0101 during HOLD
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !ob_valid; i++) step(1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0101);
        step(1'b0, 1'b0, 16'h0000);
        chk1("c_valid_drop", ob_valid, 1'b0);
        for (int i = 0; i < 10 && !ob_req; i++) step(1'b0, 1'b0, 16'h0000);
        chk1("c_req_seen", ob_req, 1'b1);
        chk("c_addr", ob_addr, 16'h0100);

        // Redirect to 0040 while the request to 0006 is outstanding
        fixed_lat = 0;
        for (int i = 0; i < 20 && !ob_valid; i++) step(1'b0, 1'b0, 16'h0000);
        ack_mode  = 1;
        fixed_lat = 1;
        step(1'b0, 1'b1, 16'h0006);
        step(1'b0, 1'b0, 16'h0000);
        chk("d_addr_0006", ob_addr, 16'h0006);
        step(1'b0, 1'b1, 16'h0040);
        step(1'b0, 1'b0, 16'h0000);
        ack_mode = 2;
        ovr_en   = 1'b1;
        ovr_data = 16'h1234;
        step(1'b0, 1'b0, 16'h0000);
        ack_mode = 0;
        ovr_en   = 1'b0;
        step(1'b1, 1'b0, 16'h0000);
        chk1("d_req", ob_req, 1'b1);
        chk("d_next_addr", ob_addr, 16'h0040);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 16'h0000);
            chk1("d_no_1234", ob_valid && (ob_ir == 16'h1234), 1'b0);
        end

        // Redirect and ack in the same FETCH cycle
        ack_mode = 1;
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !ob_req; i++) step(1'b1, 1'b0, 16'h0000);
        ack_mode = 2;
        step(1'b0, 1'b1, 16'h0200);
        ack_mode = 0;
        step(1'b0, 1'b0, 16'h0000);
        chk1("e_req", ob_req, 1'b1);
        chk("e_addr", ob_addr, 16'h0200);
        chk1("e_valid", ob_valid, 1'b0);

        // PC wrap at FFFE (odd target forced even)
        step(1'b1, 1'b1, 16'hFFFF);
        step(1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !ob_valid; i++) step(1'b0, 1'b0, 16'h0000);
        chk("f_irpc", ob_irpc, 16'hFFFE);
        step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 16'h0000);
        chk1("f_req", ob_req, 1'b1);
        chk("f_wrap_addr", ob_addr, 16'h0000);

        // Randomized traffic
        n_del     = 0;
        rand_mode = 1'b1;
        rand_lat  = 1'b1;
        for (int i = 0; i < 800; i++) step(1'b0, 1'b0, 16'h0000);
        chk1("r_progress", n_del > 50, 1'b1);
        rand_mode = 1'b0;

        // Asynchronous reset while draining a stale request
        ack_mode = 1;
        step(1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 20 && !ob_req; i++) step(1'b1, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 16'h0300);
        step(1'b0, 1'b0, 16'h0000);
        chk1("g_in_drain", ob_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("g_rst_req", mem_req, 1'b0);
        chk1("g_rst_valid", ir_valid, 1'b0);
        chk("g_rst_addr", mem_addr, 16'h0000);
        mem_ack = 1'b0;
        @(negedge clk);
        chk1("g_rst_req_hold", mem_req, 1'b0);
        rst_n     = 1'b1;
        ack_mode  = 0;
        rand_lat  = 1'b0;
        fixed_lat = 0;
        model_reset();
        step(1'b1, 1'b0, 16'h0000);
        chk1("g_restart_req", ob_req, 1'b1);
        chk("g_restart_addr", ob_addr, 16'h0000);
        rand_mode = 1'b1;
        rand_lat  = 1'b1;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Holds each fetched instruction in an instruction register (IR) until decode accepts it.
- Exposes decoded fields; the imm8 output feeds directly into the 8-to-16 sign-extension unit.
- Owns the program counter and accepts branch/jump redirects from execute.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
PC_STEP, 2, PC increment per instruction (byte-addressed, 16-bit instructions).

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_req  output  1  fetch request, registered
mem_addr  output  16  fetch address, registered, stable while mem_req=1
mem_ack  input  1  memory has mem_rdata valid this cycle for mem_addr
mem_rdata  input  16  instruction word
dec_ready  input  1  decode accepts IR this cycle
redirect  input  1  load new PC, flush IR (one-cycle pulse)
redirect_pc  input  16  redirect target
ir_valid  output  1  IR holds an instruction for decode
ir  output  16  instruction register
ir_pc  output  16  address the IR word was fetched from
opcode  output  4  ir[15:12]
imm8  output  8  ir[7:0], to sign extender

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=FETCH, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0.
- First request: mem_req rises on the first clk edge after rst_n deasserts.
- Decoded fields: opcode and imm8 are combinational slices of ir, with no added latency.
- Handshake rule: once mem_req=1, mem_addr must not change until the cycle mem_ack=1. A transfer completes on the edge where mem_req&mem_ack. An ack while mem_req=0 is ignored.
- PC arithmetic: pc+PC_STEP is modulo 2^16 (16'hFFFE+2 = 16'h0000). redirect_pc[0] is forced to 0 on load.
- State FETCH: mem_req=1, mem_addr=pc.
  - On ack: ir<=mem_rdata, ir_pc<=pc, pc<=pc+PC_STEP, ir_valid<=1, mem_req<=0, go to HOLD.
- State HOLD: ir_valid=1, mem_req=0. IR, ir_pc and fields stay stable while dec_ready=0.
  - On dec_ready: ir_valid<=0, mem_req<=1, mem_addr<=pc, go to FETCH. Next request issues the cycle after acceptance; peak rate is one instruction per 2 cycles with zero-wait memory.
- State DRAIN: a request is outstanding at the old address. Keep mem_req=1 and the old mem_addr.
  - On ack: discard mem_rdata, mem_addr<=pc, go to FETCH with mem_req kept at 1.
- Redirect (highest priority over dec_ready and ack):
  - In HOLD: pc<=redirect_pc, ir_valid<=0, go to FETCH.
  - In FETCH with mem_ack=1 the same cycle: discard data, pc<=redirect_pc, mem_addr<=redirect_pc, stay in FETCH.
  - In FETCH with mem_ack=0: pc<=redirect_pc, go to DRAIN.
  - In DRAIN: pc<=redirect_pc (latest redirect wins), stay in DRAIN until ack.
  - In all cases ir_valid drops on the edge after redirect.
- ir_valid is never asserted for a word fetched before a redirect.
- Reset mid-operation: all state returns to reset values immediately, asynchronously. An outstanding memory request is abandoned; the memory side must also be reset.

Test Plan:
- Reset, memory acks 3 cycles after each req, dec_ready=1 -> mem_addr sequence 0000,0002,0004; ir_valid pulses once per fetch; ir_pc matches.
- Fetch word 16'hA3F0 at 0000, dec_ready=0 for 5 cycles -> ir=A3F0, opcode=A, imm8=F0, ir_valid held; no new mem_req until dec_ready.
- Redirect to 16'h0101 during HOLD -> ir_valid=0 next cycle; next mem_addr=0100.
- Redirect to 0040 while req to 0006 outstanding, ack 2 cycles later with 16'h1234 -> 1234 never appears on ir with ir_valid=1; next req addr 0040.
- Redirect and mem_ack in the same FETCH cycle -> data dropped; mem_req stays 1 with mem_addr=target.
- pc=FFFE fetch and accept -> next mem_addr=0000.
- Assert rst_n=0 mid-DRAIN -> mem_req=0, ir_valid=0 immediately; restart fetch from RESET_PC.
